// File: rtl/ysyx_23060278_mdu_ctrl.sv
// RV32M multiply/divide sequencer: 32-step shift-add multiplier and restoring divider
// on unsigned magnitudes, behind a valid/ready handshake with flush abort.
//
// state | meaning
// IDLE  | ready for a new op; in_ready=1
// CALC  | one multiply/divide iteration per cycle, cnt 0..31
// DONE  | result held, out_valid=1 until out_ready
module ysyx_23060278_mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  md_op,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [31:0] mag2;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic        neg1;
  logic        neg2;

  logic        sgn1;
  logic        sgn2;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag1_in;
  logic [31:0] mag2_in;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] short_res;

  always_comb begin
    sgn1      = 1'b0;
    sgn2      = 1'b0;
    case (md_op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn1 = 1'b1;
        sgn2 = 1'b1;
      end
      3'b010:  sgn1 = 1'b1;
      default: ;
    endcase
    a_neg     = sgn1 & opdata1[31];
    b_neg     = sgn2 & opdata2[31];
    mag1_in   = a_neg ? (32'd0 - opdata1) : opdata1;
    mag2_in   = b_neg ? (32'd0 - opdata2) : opdata2;
    div_zero  = md_op[2] && (opdata2 == 32'd0);
    div_ovf   = md_op[2] && !md_op[0] && (opdata1 == 32'h8000_0000) && (opdata2 == 32'hFFFF_FFFF);
    short_res = 32'd0;
    if (div_zero)
      short_res = md_op[1] ? opdata1 : 32'hFFFF_FFFF;
    else if (!md_op[1])
      short_res = 32'h8000_0000;
  end

  // acc[63:32] is the running product high half / partial remainder,
  // acc[31:0] the remaining multiplier bits / dividend-then-quotient bits.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] acc_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mag2 : 32'd0)};
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, mag2};
    if (div_diff[32])
      div_next = {div_shift[31:0], acc[30:0], 1'b0};
    else
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    acc_next  = op_q[2] ? div_next : mul_next;
  end

  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] final_res;

  always_comb begin
    prod      = (neg1 ^ neg2) ? (64'd0 - mul_next) : mul_next;
    quo       = (neg1 ^ neg2) ? (32'd0 - div_next[31:0]) : div_next[31:0];
    rem       = neg1 ? (32'd0 - div_next[63:32]) : div_next[63:32];
    final_res = 32'd0;
    case (op_q)
      3'b000:                 final_res = prod[31:0];
      3'b001, 3'b010, 3'b011: final_res = prod[63:32];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= 3'd0;
      mag2   <= 32'd0;
      acc    <= 64'd0;
      cnt    <= 5'd0;
      neg1   <= 1'b0;
      neg2   <= 1'b0;
      result <= 32'd0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q <= md_op;
            neg1 <= a_neg;
            neg2 <= b_neg;
            mag2 <= mag2_in;
            acc  <= {32'd0, mag1_in};
            cnt  <= 5'd0;
            if (div_zero || div_ovf) begin
              result <= short_res;
              state  <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result <= final_res;
            state  <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_ysyx_23060278_mdu_ctrl.sv
// Bench for ysyx_23060278_mdu_ctrl: directed vector table, random ops against an
// arithmetic reference model, and hand-written backpressure/flush/reset sequences.
module tb_ysyx_23060278_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  md_op;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ysyx_23060278_mdu_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md_op     (md_op),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Reference: plain 64-bit arithmetic plus the RV32M special cases.
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 3'd4 && b == 32'd0) return 0;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 32;
  endfunction

  // Issue one op, measure edges from handshake to out_valid, check result, accept it.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string nm);
    int lat;
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    md_op    = op;
    opdata1  = a;
    opdata2  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_res"}, result, exp);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] held;
    logic        seen;
    int          wait_cnt;

    vecs.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32});
    vecs.push_back('{3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32});
    vecs.push_back('{3'd4, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 0});
    vecs.push_back('{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 0});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0});
    vecs.push_back('{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32});
    vecs.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        32});
    vecs.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         32});
    vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32});
    vecs.push_back('{3'd6, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32});
    vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 0});

    rst = 1'b1; in_valid = 1'b0; md_op = 3'd0; opdata1 = 32'd0; opdata2 = 32'd0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result",    result,         32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          sel;
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (sel == 2) a = 32'($urandom_range(0, 100));
      if (sel == 3) b = 32'($urandom_range(1, 15));
      do_op(op, a, b, ref_md(op, a, b), ref_lat(op, a, b), $sformatf("rand%0d_op%0d", i, op));
    end

    // Backpressure: result held and no new issue while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1; md_op = 3'd5; opdata1 = 32'd1000; opdata2 = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    held = result;
    chk("bp_result", held, ref_md(3'd5, 32'd1000, 32'd7));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_stable",    result,          held);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready),  32'd1);

    // Flush a divu at T+10: back to IDLE at T+11, never a result for it.
    @(negedge clk);
    in_valid = 1'b1; md_op = 3'd5; opdata1 = 32'd12345; opdata2 = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready",  32'(in_ready),  32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_result", 32'(seen), 32'd0);
    chk("flush_result_kept", result, 32'd142);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 32, "after_flush_mul");

    // flush together with in_valid in IDLE is not an issue.
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; md_op = 3'd4; opdata1 = 32'd5; opdata2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_issue_ready", 32'(in_ready),  32'd1);
    chk("flush_issue_valid", 32'(out_valid), 32'd0);

    // flush while a result waits in DONE drops it.
    @(negedge clk);
    in_valid = 1'b1; md_op = 3'd4; opdata1 = 32'd5; opdata2 = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("done_flush_pre", 32'(out_valid), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("done_flush_valid", 32'(out_valid), 32'd0);
    chk("done_flush_ready", 32'(in_ready),  32'd1);

    // rst at T+5 of a multiply returns every output to its reset value.
    @(negedge clk);
    in_valid = 1'b1; md_op = 3'd0; opdata1 = 32'd5; opdata2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_in_ready",  32'(in_ready),  32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result",    result,         32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("rst_no_result", 32'(seen), 32'd0);
    do_op(3'd0, 32'd5, 32'd6, 32'd30, 32, "after_rst_mul");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
